voter_session: RTL and testbench

- Sequential, parametrised voting machine.
- Opens a ballot session on START and accepts one vote per voter over successive cycles through a valid-qualified vote port.
- Closes the session when all voters have voted or a timeout expires.
- Classifies the result as lose / tie / win on one-hot O[3:1], matching the existing 4-voter decision encoding.
- Sits between the vote-entry front end and the result display logic.

---
 rtl/voter_pkg.sv | 17 +
 rtl/voter_classify.sv | 34 +++
 rtl/voter_session.sv | 179 +++++++++++++++++
 tb/tb_voter_session.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/voter_pkg.sv
// Shared definitions for the voter_session ballot machine: FSM state
// encoding and the one-hot result codes driven on O[3:1].
package voter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DECIDE  = 2'd2
  } state_t;

  // One-hot result: bit 2 lose, bit 1 tie, bit 0 win (O[3], O[2], O[1]).
  localparam logic [2:0] RES_NONE = 3'b000;
  localparam logic [2:0] RES_LOSE = 3'b100;
  localparam logic [2:0] RES_TIE  = 3'b010;
  localparam logic [2:0] RES_WIN  = 3'b001;

endpackage

// File: rtl/voter_classify.sv
// Combinational majority classifier: turns the yes-vote count into the
// one-hot lose/tie/win code. With CHAIR_EN set, a tie is broken by the
// chair's (voter 0's) vote and the tie code is never produced.
module voter_classify
  import voter_pkg::*;
#(
  parameter int N_VOTERS = 4,
  parameter int CW       = $clog2(N_VOTERS + 1),
  parameter bit CHAIR_EN = 1'b0
) (
  input  logic [CW-1:0] i_yes_cnt,
  input  logic          i_chair_yes,
  output logic [2:0]    o_result
);

  logic [CW:0] w_twice_yes;
  logic [CW:0] w_n_voters;

  // Compare 2*yes against N one bit wider than the counter so it never wraps.
  always_comb begin
    w_twice_yes = {i_yes_cnt, 1'b0};
    w_n_voters  = (CW + 1)'(N_VOTERS);
    if (w_twice_yes < w_n_voters) begin
      o_result = RES_LOSE;
    end else if (w_twice_yes > w_n_voters) begin
      o_result = RES_WIN;
    end else if (CHAIR_EN) begin
      o_result = i_chair_yes ? RES_WIN : RES_LOSE;
    end else begin
      o_result = RES_TIE;
    end
  end

endmodule

// File: rtl/voter_session.sv
// voter_session: opens a ballot on START, collects one vote per voter,
// closes when everyone has voted or the COLLECT timer expires, then spends
// one DECIDE cycle registering the classified result and pulsing DONE.
// Optional feature macro: VOTER_CHAIR_EN (voter 0 breaks ties).
module voter_session
  import voter_pkg::*;
#(
  parameter int N_VOTERS = 4,
  parameter int TIMEOUT  = 16,
  parameter int IDW      = $clog2(N_VOTERS),
  parameter int CW       = $clog2(N_VOTERS + 1)
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           START,
  input  logic           VOTE_VALID,
  input  logic [IDW-1:0] VOTE_ID,
  input  logic           VOTE_YES,
  output logic           BUSY,
  output logic           DONE,
  output logic [2:0]     O,
  output logic [CW-1:0]  YES_CNT,
  output logic [CW-1:0]  VOTED_CNT,
  output logic           VOTE_ERR,
  output logic           TIMED_OUT
);

  // Timer only has to reach TIMEOUT-1; keep at least one bit when disabled.
  localparam int             TW     = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0]  T_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  // Mask view widened to every encodable ID so out-of-range IDs index safely.
  localparam int             IDN    = 1 << IDW;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [N_VOTERS-1:0]  r_mask;
  logic [CW-1:0]        r_yes_cnt;
  logic [CW-1:0]        r_voted_cnt;
  logic [TW-1:0]        r_timer;
  logic                 r_vote_err;
  logic                 r_timed_out;
  logic [2:0]           r_o;
  logic                 r_done;

  logic [IDN-1:0]       w_mask_ext;
  logic                 w_id_in_range;
  logic                 w_accept;
  logic                 w_bad_vote;
  logic [CW-1:0]        w_voted_nxt;
  logic                 w_all_voted;
  logic                 w_timer_hit;
  logic                 w_close;
  logic                 w_busy;
  logic                 w_chair_yes;
  logic [2:0]           w_result;

`ifdef VOTER_CHAIR_EN
  localparam bit CHAIR_EN = 1'b1;
  logic r_chair_yes;

  // Remember the chair's accepted vote; an abstaining chair counts as no.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_chair_yes <= 1'b0;
    end else if (r_state == IDLE && START) begin
      r_chair_yes <= 1'b0;
    end else if (w_accept && VOTE_ID == '0) begin
      r_chair_yes <= VOTE_YES;
    end
  end

  assign w_chair_yes = r_chair_yes;
`else
  localparam bit CHAIR_EN = 1'b0;
  assign w_chair_yes = 1'b0;
`endif

  // State register.
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (RST) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic: DECIDE always lasts exactly one cycle.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (START)   w_state_nxt = COLLECT;
      COLLECT: if (w_close) w_state_nxt = DECIDE;
      DECIDE:               w_state_nxt = IDLE;
      default:              w_state_nxt = IDLE;
    endcase
  end

  // Output/decode logic: vote acceptance, close conditions and BUSY.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    w_mask_ext    = IDN'(r_mask);
    w_id_in_range = ({{(32 - IDW){1'b0}}, VOTE_ID} < 32'(N_VOTERS));
    w_accept      = 1'b0;
    w_bad_vote    = 1'b0;
    w_busy        = (r_state == COLLECT) || (r_state == DECIDE);
    if (r_state == COLLECT && VOTE_VALID) begin
      w_accept   = w_id_in_range && !w_mask_ext[VOTE_ID];
      w_bad_vote = !w_accept;
    end
    w_voted_nxt = r_voted_cnt + CW'(w_accept);
    w_all_voted = (w_voted_nxt == CW'(N_VOTERS));
    w_timer_hit = (TIMEOUT != 0) && (r_timer == T_LAST);
    w_close     = (r_state == COLLECT) && (w_all_voted || w_timer_hit);
  end

  voter_classify #(
    .N_VOTERS (N_VOTERS),
    .CW       (CW),
    .CHAIR_EN (CHAIR_EN)
  ) u_classify (
    .i_yes_cnt   (r_yes_cnt),
    .i_chair_yes (w_chair_yes),
    .o_result    (w_result)
  );

  // Ballot datapath: mask, counters, timer, sticky flags and the result.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_mask      <= '0;
      r_yes_cnt   <= '0;
      r_voted_cnt <= '0;
      r_timer     <= '0;
      r_vote_err  <= 1'b0;
      r_timed_out <= 1'b0;
      r_o         <= RES_NONE;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (START) begin
            r_mask      <= '0;
            r_yes_cnt   <= '0;
            r_voted_cnt <= '0;
            r_timer     <= '0;
            r_vote_err  <= 1'b0;
            r_timed_out <= 1'b0;
            r_o         <= RES_NONE;
          end
        end
        COLLECT: begin
          r_timer <= r_timer + TW'(1);
          if (w_accept) begin
            r_mask      <= r_mask | (N_VOTERS'(1) << VOTE_ID);
            r_voted_cnt <= w_voted_nxt;
            r_yes_cnt   <= r_yes_cnt + CW'(VOTE_YES);
          end
          if (w_bad_vote) r_vote_err <= 1'b1;
          // A vote landing on the timeout edge still counts first.
          if (w_timer_hit && !w_all_voted) r_timed_out <= 1'b1;
        end
        DECIDE: begin
          r_o    <= w_result;
          r_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign BUSY      = w_busy;
  assign DONE      = r_done;
  assign O         = r_o;
  assign YES_CNT   = r_yes_cnt;
  assign VOTED_CNT = r_voted_cnt;
  assign VOTE_ERR  = r_vote_err;
  assign TIMED_OUT = r_timed_out;

endmodule

// File: tb/tb_voter_session.sv
// Self-checking bench for voter_session. Two instances: N=4/TIMEOUT=8 for
// the main behaviour and N=5/TIMEOUT=0 so out-of-range IDs are encodable.
// A session-level model (vote set, tallies, close cycle) predicts outputs.
module tb_voter_session;

  localparam int N4 = 4, T4 = 8;
  localparam int N5 = 5, T5 = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start4, start5, vote_valid, vote_yes;
  logic [2:0] vote_id;

  logic       busy4, done4, err4, tmo4;
  logic [2:0] o4, yes4, voted4;
  logic       busy5, done5, err5, tmo5;
  logic [2:0] o5, yes5, voted5;

  voter_session #(.N_VOTERS(N4), .TIMEOUT(T4)) dut4 (
    .CLK(clk), .RST(rst), .START(start4), .VOTE_VALID(vote_valid),
    .VOTE_ID(vote_id[1:0]), .VOTE_YES(vote_yes), .BUSY(busy4), .DONE(done4),
    .O(o4), .YES_CNT(yes4), .VOTED_CNT(voted4), .VOTE_ERR(err4),
    .TIMED_OUT(tmo4)
  );

  voter_session #(.N_VOTERS(N5), .TIMEOUT(T5)) dut5 (
    .CLK(clk), .RST(rst), .START(start5), .VOTE_VALID(vote_valid),
    .VOTE_ID(vote_id), .VOTE_YES(vote_yes), .BUSY(busy5), .DONE(done5),
    .O(o5), .YES_CNT(yes5), .VOTED_CNT(voted5), .VOTE_ERR(err5),
    .TIMED_OUT(tmo5)
  );

  // Observe whichever instance is currently under test.
  logic       sel;
  logic       busy, done, err, tmo;
  logic [2:0] o, yes_cnt, voted_cnt;
  always_comb begin
    busy = sel ? busy5 : busy4;   done = sel ? done5 : done4;
    err  = sel ? err5  : err4;    tmo  = sel ? tmo5  : tmo4;
    o    = sel ? o5    : o4;      yes_cnt = sel ? yes5 : yes4;
    voted_cnt = sel ? voted5 : voted4;
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct {
    bit         v;
    logic [2:0] id;
    bit         y;
    bit         s;
  } ev_t;
  ev_t ev_q[$];

  function automatic void push(input bit v, input int id, input bit y);
    ev_t e;
    e.v = v; e.id = 3'(id); e.y = y; e.s = 1'b0;
    ev_q.push_back(e);
  endfunction

  // Result from the majority rule; ties go to the chair when enabled.
  function automatic logic [2:0] exp_result(input int yes, input int n,
                                            input bit chair);
    if (2 * yes < n) return 3'b100;
    if (2 * yes > n) return 3'b001;
`ifdef VOTER_CHAIR_EN
    return chair ? 3'b001 : 3'b100;
`else
    return (chair && 1'b0) ? 3'b000 : 3'b010;
`endif
  endfunction

  task automatic drive_idle_random();
    vote_valid = 1'($urandom); vote_id = 3'($urandom); vote_yes = 1'($urandom);
  endtask

  // One ballot from START to result, consuming ev_q one event per cycle.
  task automatic run_session(input bit back_to_back);
    int  n, t, k, id, yes, voted;
    bit  seen[8];
    bit  err_m, chair, tmo_m, closed;
    ev_t e;
    n = sel ? N5 : N4;
    t = sel ? T5 : T4;
    k = 0; yes = 0; voted = 0;
    err_m = 0; chair = 0; tmo_m = 0; closed = 0;
    foreach (seen[i]) seen[i] = 1'b0;

    start4 = !sel; start5 = sel;
    drive_idle_random();
    @(posedge clk); #1;
    start4 = 1'b0; start5 = 1'b0;
    check("start_busy", busy, 1);
    check("start_done", done, 0);
    check("start_o", o, 0);
    check("start_yes", yes_cnt, 0);
    check("start_voted", voted_cnt, 0);
    check("start_err", err, 0);
    check("start_tmo", tmo, 0);

    while (!closed && k < 100) begin
      if (ev_q.size() > 0) e = ev_q.pop_front();
      else begin e.v = 0; e.id = 3'($urandom); e.y = 1'($urandom); e.s = 0; end
      vote_valid = e.v; vote_id = e.id; vote_yes = e.y;
      start4 = !sel && e.s; start5 = sel && e.s;
      if (e.v) begin
        id = sel ? int'(e.id) : int'(e.id[1:0]);
        if (id < n && !seen[id]) begin
          seen[id] = 1'b1;
          voted++;
          yes += int'(e.y);
          if (id == 0) chair = e.y;
        end else begin
          err_m = 1'b1;
        end
      end
      closed = (voted == n) || (t != 0 && k == t - 1);
      tmo_m  = closed && (voted < n);
      @(posedge clk); #1;
      check("col_busy", busy, 1);
      check("col_done", done, 0);
      check("col_voted", voted_cnt, voted);
      check("col_yes", yes_cnt, yes);
      check("col_err", err, err_m);
      k++;
    end
    ev_q.delete();

    start4 = 1'b0; start5 = 1'b0;
    drive_idle_random();
    @(posedge clk); #1;
    check("dec_done", done, 1);
    check("dec_busy", busy, 0);
    check("dec_o", o, exp_result(yes, n, chair));
    check("dec_tmo", tmo, tmo_m);
    check("dec_voted", voted_cnt, voted);
    check("dec_yes", yes_cnt, yes);
    check("dec_err", err, err_m);

    if (!back_to_back) begin
      drive_idle_random();
      @(posedge clk); #1;
      check("hold_done", done, 0);
      check("hold_busy", busy, 0);
      check("hold_o", o, exp_result(yes, n, chair));
      check("hold_voted", voted_cnt, voted);
      check("hold_yes", yes_cnt, yes);
    end
  endtask

  initial begin
    rst = 1'b1; start4 = 1'b0; start5 = 1'b0; sel = 1'b0;
    vote_valid = 1'b0; vote_id = '0; vote_yes = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_o", o, 0);
    check("rst_voted", voted_cnt, 0);
    check("rst_busy5", busy5, 0);
    rst = 1'b0;

    // Even split Y,Y,N,N -> tie (chair yes breaks it to win when enabled).
    push(1, 0, 1); push(1, 1, 1); push(1, 2, 0); push(1, 3, 0);
    run_session(0);
    push(1, 0, 1); push(1, 1, 1); push(1, 2, 1); push(1, 3, 0);
    run_session(0);
    push(1, 0, 0); push(1, 1, 0); push(1, 2, 0); push(1, 3, 0);
    run_session(0);
    push(1, 0, 0); push(1, 1, 0); push(1, 2, 0); push(1, 3, 1);
    run_session(0);
    // Only voter 2 votes: timeout after the eighth COLLECT cycle.
    push(1, 2, 1);
    run_session(0);
    // Duplicate vote by voter 1 flags VOTE_ERR without changing tallies.
    push(1, 1, 1); push(1, 1, 0); push(0, 0, 0); push(1, 0, 0);
    push(1, 2, 1); push(1, 3, 1);
    run_session(0);
    // Tie broken by the chair (voter 0) yes, then by a chair no.
    push(1, 0, 1); push(1, 3, 1);
    run_session(1);
    push(1, 0, 0); push(1, 1, 1); push(1, 2, 1);
    run_session(0);

    // Reset in the middle of COLLECT after two votes.
    start4 = 1'b1; vote_valid = 1'b0;
    @(posedge clk); #1;
    start4 = 1'b0;
    vote_valid = 1'b1; vote_id = 3'd0; vote_yes = 1'b1;
    @(posedge clk); #1;
    vote_id = 3'd1;
    @(posedge clk); #1;
    check("mid_voted", voted_cnt, 2);
    rst = 1'b1; vote_id = 3'd2;
    @(posedge clk); #1;
    check("mrst_busy", busy, 0);
    check("mrst_voted", voted_cnt, 0);
    check("mrst_yes", yes_cnt, 0);
    check("mrst_o", o, 0);
    check("mrst_err", err, 0);
    rst = 1'b0; vote_id = 3'd3;
    @(posedge clk); #1;
    check("post_rst_voted", voted_cnt, 0);
    check("post_rst_busy", busy, 0);
    vote_valid = 1'b0;

    for (int s = 0; s < 30; s++) begin
      int len;
      len = $urandom_range(1, 10);
      for (int j = 0; j < len; j++) begin
        ev_t e;
        e.v = ($urandom_range(0, 3) != 0);
        e.id = 3'($urandom_range(0, 7));
        e.y = 1'($urandom);
        e.s = 1'($urandom);
        ev_q.push_back(e);
      end
      run_session($urandom_range(0, 3) == 0);
    end

    // N=5 instance: out-of-range IDs 5..7 and no timeout.
    sel = 1'b1;
    push(1, 5, 1); push(1, 0, 1); push(1, 7, 0); push(1, 1, 0);
    push(1, 2, 1); push(1, 6, 1); push(1, 3, 0); push(1, 4, 1);
    run_session(0);
    for (int s = 0; s < 15; s++) begin
      int len, off;
      len = $urandom_range(0, 6);
      for (int j = 0; j < len; j++) begin
        ev_t e;
        e.v = 1'($urandom);
        e.id = 3'($urandom_range(0, 7));
        e.y = 1'($urandom);
        e.s = 1'($urandom);
        ev_q.push_back(e);
      end
      off = $urandom_range(0, 4);
      for (int j = 0; j < 5; j++) push(1, (off + j) % 5, 1'($urandom));
      run_session($urandom_range(0, 3) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
